rename_ckpt_ctrl: RTL and testbench

- Branch checkpoint controller for the rename stage.
- Allocates a rename-map snapshot slot for every renamed branch and tracks the outstanding branches in program order.
- Frees the oldest slot on a correctly predicted branch result. On a mispredict, sequences the recovery: a one-cycle restore pulse to the rename map and free list, then a fixed drain window.
- Stalls rename whenever no slot is free or recovery is in progress.

---
 rtl/rename_ckpt_ctrl.sv | 134 +++++++++++++
 tb/tb_rename_ckpt_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_ckpt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rename_ckpt_ctrl
// Description : Branch checkpoint controller for the rename stage. Allocates
//               a map-snapshot slot per renamed branch, retires the oldest
//               slot on a correct prediction and sequences mispredict
//               recovery (one-cycle restore pulse, then a drain window).
// Revision    : 1.0 - initial release
// ============================================================================
module rename_ckpt_ctrl #(
  parameter int NUM_CKPT     = 4,
  parameter int TAG_W        = $clog2(NUM_CKPT),
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_i,
  input  logic                          br_valid_i,
  output logic                          br_accept_o,
  output logic                          snap_we_o,
  output logic [TAG_W-1:0]              snap_tag_o,
  input  logic                          br_result_valid_i,
  input  logic                          br_result_hit_i,
  output logic                          restore_o,
  output logic [TAG_W-1:0]              restore_tag_o,
  output logic                          stall_o,
  output logic [$clog2(NUM_CKPT+1)-1:0] ckpt_count_o,
  output logic                          underflow_o
);

  localparam int CNT_W = $clog2(NUM_CKPT + 1);
  localparam logic [CNT_W-1:0] c_num_ckpt = CNT_W'(NUM_CKPT);
  // Drain counter reload; FLUSH_CYCLES==0 skips DRAIN entirely so the value is unused then
  localparam logic [3:0] c_drain_load = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESTORE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_drain, w_drain_nxt;
  logic [TAG_W-1:0] r_head, r_tail, r_restore_tag;
  logic [CNT_W-1:0] r_count;
  logic             r_restore, r_underflow;

  logic w_idle, w_full, w_empty, w_miss, w_hit, w_accept, w_uf_evt;

  // Grant, stall and result classification from the pre-update state
  always_comb begin
    w_idle   = (r_state == S_IDLE);
    w_full   = (r_count == c_num_ckpt);
    w_empty  = (r_count == '0);
    w_miss   = br_result_valid_i & ~br_result_hit_i & w_idle & ~w_empty;
    w_hit    = br_result_valid_i &  br_result_hit_i & w_idle & ~w_empty;
    w_uf_evt = br_result_valid_i & w_idle & w_empty;
    w_accept = br_valid_i & w_idle & ~w_full & ~w_miss;
  end

  // Recovery sequencer next-state: RESTORE for one cycle, then the drain window
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain;
    case (r_state)
      S_IDLE: begin
        if (w_miss) w_state_nxt = S_RESTORE;
      end
      S_RESTORE: begin
        if (FLUSH_CYCLES == 0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = c_drain_load;
        end
      end
      S_DRAIN: begin
        if (r_drain == 4'd0) w_state_nxt = S_IDLE;
        else                 w_drain_nxt = r_drain - 4'd1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_drain_nxt = 4'd0;
      end
    endcase
  end

  // State register for the recovery sequencer
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_drain <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // Checkpoint ring pointers, occupancy, restore pulse and sticky underflow
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_restore     <= 1'b0;
      r_restore_tag <= '0;
      r_underflow   <= 1'b0;
    end else begin
      r_restore <= w_miss;
      if (w_uf_evt) r_underflow <= 1'b1;
      if (w_miss) begin
        // Squash every younger checkpoint: the ring restarts just past the missed slot
        r_restore_tag <= r_head;
        r_head        <= r_head + TAG_W'(1);
        r_tail        <= r_head + TAG_W'(1);
        r_count       <= '0;
      end else begin
        if (w_accept) r_tail <= r_tail + TAG_W'(1);
        if (w_hit)    r_head <= r_head + TAG_W'(1);
        r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_hit);
      end
    end
  end

  assign br_accept_o   = w_accept;
  assign snap_we_o     = w_accept;
  assign snap_tag_o    = r_tail;
  assign restore_o     = r_restore;
  assign restore_tag_o = r_restore_tag;
  assign stall_o       = w_full | ~w_idle | w_miss;
  assign ckpt_count_o  = r_count;
  assign underflow_o   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_rename_ckpt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_ckpt_ctrl
// Description : Self-checking bench for rename_ckpt_ctrl: directed scenarios
//               plus a randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_ckpt_ctrl;

  localparam int NUM_CKPT     = 4;
  localparam int TAG_W        = 2;
  localparam int FLUSH_CYCLES = 2;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             br_valid_i, br_result_valid_i, br_result_hit_i;
  logic             br_accept_o, snap_we_o, restore_o, stall_o, underflow_o;
  logic [TAG_W-1:0] snap_tag_o, restore_tag_o;
  logic [2:0]       ckpt_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  rename_ckpt_ctrl #(
    .NUM_CKPT     (NUM_CKPT),
    .TAG_W        (TAG_W),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk               (clk),
    .rst_i             (rst_i),
    .br_valid_i        (br_valid_i),
    .br_accept_o       (br_accept_o),
    .snap_we_o         (snap_we_o),
    .snap_tag_o        (snap_tag_o),
    .br_result_valid_i (br_result_valid_i),
    .br_result_hit_i   (br_result_hit_i),
    .restore_o         (restore_o),
    .restore_tag_o     (restore_tag_o),
    .stall_o           (stall_o),
    .ckpt_count_o      (ckpt_count_o),
    .underflow_o       (underflow_o)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rv, input logic rh);
    br_valid_i        = v;
    br_result_valid_i = rv;
    br_result_hit_i   = rh;
    #2;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_i = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (ckpt_count_o !== 3'd0 || restore_o !== 1'b0 || restore_tag_o !== 2'd0 ||
        underflow_o !== 1'b0 || stall_o !== 1'b0 || snap_tag_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d restore=%b rtag=%0d uf=%b stall=%b tag=%0d, required 0 0 0 0 0 0",
               ckpt_count_o, restore_o, restore_tag_o, underflow_o, stall_o, snap_tag_o);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < NUM_CKPT; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (br_accept_o !== 1'b1 || snap_we_o !== 1'b1 || snap_tag_o !== TAG_W'(i)) begin
        n_fail++;
        $display("FAIL fill_alloc[%0d]: accept=%b we=%b tag=%0d, required 1 1 %0d",
                 i, br_accept_o, snap_we_o, snap_tag_o, i);
      end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ckpt_count_o !== 3'd4 || br_accept_o !== 1'b0 || stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_full: count=%0d accept=%b stall=%b, required 4 0 1",
               ckpt_count_o, br_accept_o, stall_o);
    end
  endtask

  // Runs from the full state left by test_fill (head 0)
  task automatic test_hit_when_full();
    drive(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (br_accept_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_hit_accept: accept=%b, required 0", br_accept_o);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ckpt_count_o !== 3'd3 || br_accept_o !== 1'b1 || snap_tag_o !== 2'd0) begin
      n_fail++;
      $display("FAIL full_hit_retry: count=%0d accept=%b tag=%0d, required 3 1 0",
               ckpt_count_o, br_accept_o, snap_tag_o);
    end
    tick();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (restore_o !== 1'b1 || restore_tag_o !== 2'd1 || ckpt_count_o !== 3'd0) begin
      n_fail++;
      $display("FAIL full_hit_head: restore=%b rtag=%0d count=%0d, required 1 1 0",
               restore_o, restore_tag_o, ckpt_count_o);
    end
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < FLUSH_CYCLES + 1; i++) tick();
  endtask

  task automatic test_miss_recovery();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (stall_o !== 1'b1 || restore_o !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_cycle_n: stall=%b restore=%b, required 1 0", stall_o, restore_o);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (restore_o !== 1'b1 || restore_tag_o !== 2'd0 || ckpt_count_o !== 3'd0 || stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_restore: restore=%b rtag=%0d count=%0d stall=%b, required 1 0 0 1",
               restore_o, restore_tag_o, ckpt_count_o, stall_o);
    end
    for (int c = 2; c <= 1 + FLUSH_CYCLES; c++) begin
      tick();
      n_checks++;
      if (restore_o !== 1'b0 || stall_o !== 1'b1) begin
        n_fail++;
        $display("FAIL miss_drain[N+%0d]: restore=%b stall=%b, required 0 1", c, restore_o, stall_o);
      end
    end
    tick();
    drive(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (stall_o !== 1'b0 || br_accept_o !== 1'b1 || snap_tag_o !== 2'd1) begin
      n_fail++;
      $display("FAIL miss_resume: stall=%b accept=%b tag=%0d, required 0 1 1",
               stall_o, br_accept_o, snap_tag_o);
    end
    tick();
  endtask

  task automatic test_miss_with_branch();
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (br_accept_o !== 1'b0 || snap_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_vs_branch: accept=%b we=%b, required 0 0", br_accept_o, snap_we_o);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (br_accept_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_branch: accept=%b, required 0", br_accept_o);
    end
    tick();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (underflow_o !== 1'b0 || ckpt_count_o !== 3'd0 || stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_result_ignored: uf=%b count=%0d stall=%b, required 0 0 0",
               underflow_o, ckpt_count_o, stall_o);
    end
    drive(1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (underflow_o !== 1'b1 || ckpt_count_o !== 3'd0) begin
      n_fail++;
      $display("FAIL underflow_sticky: uf=%b count=%0d, required 1 0", underflow_o, ckpt_count_o);
    end
    do_reset();
    n_checks++;
    if (underflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_reset: uf=%b, required 0", underflow_o);
    end
  endtask

  task automatic test_reset_in_restore();
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    rst_i = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (restore_o !== 1'b0 || ckpt_count_o !== 3'd0 || stall_o !== 1'b0 ||
        br_accept_o !== 1'b1 || snap_tag_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_in_restore: restore=%b count=%0d stall=%b accept=%b tag=%0d, required 0 0 0 1 0",
               restore_o, ckpt_count_o, stall_o, br_accept_o, snap_tag_o);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (restore_o !== 1'b0 || ckpt_count_o !== 3'd1) begin
      n_fail++;
      $display("FAIL reset_in_restore_after: restore=%b count=%0d, required 0 1", restore_o, ckpt_count_o);
    end
  endtask

  // Reference model: outstanding tags in program order, stalled-cycle budget after a miss
  task automatic test_random();
    int  q[$];
    int  next_tag = 0;
    int  recov    = 0;
    bit  exp_restore = 0;
    int  exp_rtag    = 0;
    bit  exp_uf      = 0;
    int  errs        = 0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit v, rv, rh, idle, full, miss, acc, stall;
      v  = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 2) == 0);
      rh = ($urandom_range(0, 4) != 0);
      drive(v, rv, rh);
      idle  = (recov == 0);
      full  = (q.size() == NUM_CKPT);
      miss  = rv && !rh && idle && q.size() != 0;
      acc   = v && idle && !full && !miss;
      stall = full || !idle || miss;
      n_checks++;
      if (br_accept_o !== acc || snap_we_o !== acc || stall_o !== stall ||
          snap_tag_o !== TAG_W'(next_tag) || ckpt_count_o !== 3'(q.size()) ||
          restore_o !== exp_restore || restore_tag_o !== TAG_W'(exp_rtag) ||
          underflow_o !== exp_uf) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: acc=%b stall=%b tag=%0d cnt=%0d rst=%b rtag=%0d uf=%b, required %b %b %0d %0d %b %0d %b",
                   cyc, br_accept_o, stall_o, snap_tag_o, ckpt_count_o, restore_o, restore_tag_o,
                   underflow_o, acc, stall, next_tag, q.size(), exp_restore, exp_rtag, exp_uf);
      end
      exp_restore = miss;
      if (miss) begin
        exp_rtag = q[0];
        next_tag = (q[0] + 1) % NUM_CKPT;
        q.delete();
        recov = 1 + FLUSH_CYCLES;
      end else if (recov > 0) begin
        recov--;
      end else begin
        if (rv && q.size() == 0) exp_uf = 1;
        if (rv && rh && q.size() != 0) void'(q.pop_front());
        if (acc) begin
          q.push_back(next_tag);
          next_tag = (next_tag + 1) % NUM_CKPT;
        end
      end
      tick();
    end
  endtask

  initial begin
    rst_i = 1'b1;
    br_valid_i = 1'b0;
    br_result_valid_i = 1'b0;
    br_result_hit_i = 1'b0;
    #1;
    test_reset();
    test_fill();
    test_hit_when_full();
    test_miss_recovery();
    test_miss_with_branch();
    test_reset_in_restore();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
